// File: rtl/spike_event_arbiter.sv
// rtl/spike_event_arbiter.sv - round-robin merge of spike-event sources into the spike-address FIFO
//
// Purpose:
//   Merges NUM_SRC valid/ready spike-event sources into one registered FIFO write
//   port. Sources are served round-robin. Arbitration stops while the controller
//   holds or the FIFO is almost full. Accepted events are counted per timestep in
//   a saturating counter.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   i_src_valid     - per-source event valid
//   i_src_addr      - per-source address, source k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_src_ready     - one-hot grant (combinational), transfer on valid & ready
//   i_hold          - controller freeze of new grants
//   i_fifo_afull    - FIFO holds >= DEPTH-1 entries
//   o_fifo_wr_en    - registered FIFO write strobe
//   o_fifo_wdata    - registered FIFO write data
//   o_grant_src     - registered source index of the current write
//   i_count_clr     - clear the event counter (timestep boundary)
//   o_event_count   - saturating count of accepted events since last clear
module spike_event_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int CNT_WIDTH  = 16,
    localparam int PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] i_src_addr,
    output logic [NUM_SRC-1:0]            o_src_ready,
    input  logic                          i_hold,
    input  logic                          i_fifo_afull,
    output logic                          o_fifo_wr_en,
    output logic [ADDR_WIDTH-1:0]         o_fifo_wdata,
    output logic [PTR_W-1:0]              o_grant_src,
    input  logic                          i_count_clr,
    output logic [CNT_WIDTH-1:0]          o_event_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wdata;
    logic [PTR_W-1:0]      r_grant_src;

    logic                  w_en;
    logic                  w_accept;
    logic [NUM_SRC-1:0]    w_grant_vec;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_rr_next;
    logic [ADDR_WIDTH-1:0] w_grant_addr;

    // rst_n is folded in so ready is forced low for the whole reset pulse,
    // independent of whatever the sources drive.
    assign w_en = rst_n && !i_hold && !i_fifo_afull;

    // Scan from rr_ptr upward (mod NUM_SRC); the first valid source wins.
    always_comb begin
        int idx;
        int nxt;
        idx          = 0;
        nxt          = 0;
        w_accept     = 1'b0;
        w_grant_vec  = '0;
        w_grant_idx  = '0;
        w_rr_next    = r_rr_ptr;
        w_grant_addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_SRC;
            if (w_en && !w_accept && i_src_valid[idx]) begin
                nxt              = (idx + 1) % NUM_SRC;
                w_accept         = 1'b1;
                w_grant_vec[idx] = 1'b1;
                w_grant_idx      = idx[PTR_W-1:0];
                w_rr_next        = nxt[PTR_W-1:0];
                w_grant_addr     = i_src_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign o_src_ready = w_grant_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_wr_en     <= 1'b0;
            r_wdata     <= '0;
            r_grant_src <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wdata     <= w_grant_addr;
                r_grant_src <= w_grant_idx;
                r_rr_ptr    <= w_rr_next;
            end
        end
    end

    // Clear takes effect before the same-cycle increment, so clear+accept gives 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_count_clr) begin
            r_count <= w_accept ? CNT_WIDTH'(1) : '0;
        end else if (w_accept && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_fifo_wr_en  = r_wr_en;
    assign o_fifo_wdata  = r_wdata;
    assign o_grant_src   = r_grant_src;
    assign o_event_count = r_count;

endmodule
